// File: rtl/regstatus_snapshot_ctrl.sv
// Busy-vector checkpoint/restore sequencer for speculative branches.
// Optional commit-order check enabled by defining REGSNAP_ORDERCHK_EN.
module regstatus_snapshot_ctrl #(
  parameter int WIDTH     = 31,
  parameter int ROB       = 2,
  parameter int SLOTS     = 4,
  parameter int TAG       = 1,
  parameter int DRAIN_CYC = 2
) (
  input  logic           clk,
  input  logic           globalResetN,
  input  logic           takeSnap,
  input  logic [WIDTH:0] regStatusSnap,
  input  logic [ROB:0]   snapROB,
  output logic           snapReady,
  output logic [TAG:0]   snapTag,
  input  logic           commitBranch,
  input  logic [ROB:0]   commitROB,
  input  logic           commitMispredict,
  output logic [WIDTH:0] statusRestore,
  output logic           restoreValid,
  output logic           orderErr
);

  localparam int DW = $clog2(DRAIN_CYC + 1);

  localparam logic [TAG+1:0] CNT_ONE    = (TAG + 2)'(1);
  localparam logic [TAG+1:0] CNT_FULL   = (TAG + 2)'(SLOTS);
  localparam logic [TAG:0]   PTR_ONE    = (TAG + 1)'(1);
  localparam logic [DW-1:0]  DRAIN_LOAD = DW'(DRAIN_CYC);
  localparam logic [DW-1:0]  DRAIN_ONE  = DW'(1);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_RESTORE,
    ST_DRAIN
  } state_t;

  state_t         state, state_nxt;
  logic [WIDTH:0] slot_vec [SLOTS];
  logic [ROB:0]   slot_rob [SLOTS];
  logic [TAG:0]   head, tail;
  logic [TAG+1:0] count;
  logic [DW-1:0]  drain_cnt;
  logic [WIDTH:0] restore_vec;

  logic in_run, alloc, hit, pop, flush;

  assign in_run    = (state == ST_RUN);
  assign snapReady = in_run && (count != CNT_FULL);
  assign snapTag   = tail;
  assign alloc     = takeSnap && snapReady;
  assign hit       = in_run && commitBranch && (count != '0) && (slot_rob[head] == commitROB);
  assign pop       = hit && !commitMispredict;
  assign flush     = hit && commitMispredict;

  assign statusRestore = restore_vec;
  assign restoreValid  = (state == ST_RESTORE);

  always_ff @(posedge clk or negedge globalResetN) begin
    if (!globalResetN) state <= ST_RUN;
    else               state <= state_nxt;
  end

  always_comb begin
    // NOTE: next state defaults to the current one so no path leaves it unassigned (no latch).
    state_nxt = state;
    unique case (state)
      ST_RUN:     if (flush) state_nxt = ST_RESTORE;
      ST_RESTORE: state_nxt = ST_DRAIN;
      ST_DRAIN:   if (drain_cnt == DRAIN_ONE) state_nxt = ST_RUN;
      default:    state_nxt = ST_RUN;
    endcase
  end

  // NOTE: slot storage has no reset; entries are only read once count says they are valid.
  always_ff @(posedge clk) begin
    if (alloc && !flush) begin
      slot_vec[tail] <= regStatusSnap;
      slot_rob[tail] <= snapROB;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clk or negedge globalResetN) begin
    if (!globalResetN) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      drain_cnt   <= '0;
      restore_vec <= '0;
    end else begin
      if (flush) begin
        // A mispredict flushes every younger checkpoint, including a same-cycle allocate.
        head        <= '0;
        tail        <= '0;
        count       <= '0;
        restore_vec <= slot_vec[head];
      end else begin
        if (alloc) tail <= tail + PTR_ONE;
        if (pop)   head <= head + PTR_ONE;
        unique case ({alloc, pop})
          2'b10:   count <= count + CNT_ONE;
          2'b01:   count <= count - CNT_ONE;
          default: count <= count;
        endcase
      end

      if (state == ST_RESTORE)    drain_cnt <= DRAIN_LOAD;
      else if (state == ST_DRAIN) drain_cnt <= drain_cnt - DRAIN_ONE;
    end
  end

`ifdef REGSNAP_ORDERCHK_EN
  logic order_err;

  always_ff @(posedge clk or negedge globalResetN) begin
    if (!globalResetN)                        order_err <= 1'b0;
    else if (in_run && commitBranch && !hit)  order_err <= 1'b1;
  end

  assign orderErr = order_err;
`else
  assign orderErr = 1'b0;
`endif

endmodule

// File: tb/tb_regstatus_snapshot_ctrl.sv
// Self-checking bench for regstatus_snapshot_ctrl: directed table, corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_regstatus_snapshot_ctrl;

  localparam int SLOTS     = 4;
  localparam int DRAIN_CYC = 2;
`ifdef REGSNAP_ORDERCHK_EN
  localparam bit OE_ON = 1'b1;
`else
  localparam bit OE_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        globalResetN;
  logic        takeSnap;
  logic [31:0] regStatusSnap;
  logic [2:0]  snapROB;
  logic        snapReady;
  logic [1:0]  snapTag;
  logic        commitBranch;
  logic [2:0]  commitROB;
  logic        commitMispredict;
  logic [31:0] statusRestore;
  logic        restoreValid;
  logic        orderErr;

  int total = 0;
  int bad   = 0;

  regstatus_snapshot_ctrl dut (
    .clk              (clk),
    .globalResetN     (globalResetN),
    .takeSnap         (takeSnap),
    .regStatusSnap    (regStatusSnap),
    .snapROB          (snapROB),
    .snapReady        (snapReady),
    .snapTag          (snapTag),
    .commitBranch     (commitBranch),
    .commitROB        (commitROB),
    .commitMispredict (commitMispredict),
    .statusRestore    (statusRestore),
    .restoreValid     (restoreValid),
    .orderErr         (orderErr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        take;
    logic [31:0] vec;
    logic [2:0]  rob;
    logic        cb;
    logic [2:0]  crob;
    logic        cmisp;
    logic        ready;
    logic [1:0]  tag;
    logic        rv;
    logic [31:0] rest;
    logic        oe;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t mk(logic take, logic [31:0] vec, logic [2:0] rob,
                              logic cb, logic [2:0] crob, logic cmisp,
                              logic ready, logic [1:0] tag, logic rv,
                              logic [31:0] rest, logic oe);
    vec_t v;
    v.take = take; v.vec = vec; v.rob = rob;
    v.cb = cb; v.crob = crob; v.cmisp = cmisp;
    v.ready = ready; v.tag = tag; v.rv = rv; v.rest = rest; v.oe = oe;
    return v;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    takeSnap = 1'b0; regStatusSnap = '0; snapROB = '0;
    commitBranch = 1'b0; commitROB = '0; commitMispredict = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    globalResetN = 1'b0;
    tick();
    globalResetN = 1'b1;
  endtask

  task automatic drive(logic take, logic [31:0] vec, logic [2:0] rob,
                       logic cb, logic [2:0] crob, logic cmisp);
    takeSnap = take; regStatusSnap = vec; snapROB = rob;
    commitBranch = cb; commitROB = crob; commitMispredict = cmisp;
  endtask

  // Reference model: program-ordered queue of checkpoints plus a count of blocked cycles.
  logic [31:0] mq_vec[$];
  logic [2:0]  mq_rob[$];
  int          m_blk;
  int          m_nalloc;
  logic [31:0] m_rest;
  logic        m_oe;

  task automatic model_reset();
    mq_vec.delete(); mq_rob.delete();
    m_blk = 0; m_nalloc = 0; m_rest = '0; m_oe = 1'b0;
  endtask

  task automatic model_check(string tagname);
    logic ready_e;
    ready_e = (m_blk == 0) && (mq_vec.size() < SLOTS);
    check({tagname, "_ready"}, snapReady, ready_e);
    check({tagname, "_tag"}, snapTag, m_nalloc % SLOTS);
    check({tagname, "_rv"}, restoreValid, m_blk == DRAIN_CYC + 1);
    check({tagname, "_rest"}, statusRestore, m_rest);
    check({tagname, "_oe"}, orderErr, m_oe);
  endtask

  task automatic model_step();
    bit ready_e, match;
    if (m_blk > 0) begin
      m_blk--;
      return;
    end
    ready_e = mq_vec.size() < SLOTS;
    match   = commitBranch && (mq_vec.size() > 0) && (mq_rob[0] == commitROB);
    if (commitBranch && !match) m_oe = m_oe | OE_ON;
    if (match && commitMispredict) begin
      m_rest = mq_vec[0];
      mq_vec.delete(); mq_rob.delete();
      m_nalloc = 0;
      m_blk = DRAIN_CYC + 1;
    end else begin
      if (match) begin
        void'(mq_vec.pop_front());
        void'(mq_rob.pop_front());
      end
      if (takeSnap && ready_e) begin
        mq_vec.push_back(regStatusSnap);
        mq_rob.push_back(snapROB);
        m_nalloc++;
      end
    end
  endtask

  initial begin
    idle_inputs();
    globalResetN = 1'b0;
    #3;
    check("rst_ready", snapReady, 1);
    check("rst_tag", snapTag, 0);
    check("rst_rest", statusRestore, 0);
    check("rst_rv", restoreValid, 0);
    check("rst_oe", orderErr, 0);
    tick();
    globalResetN = 1'b1;

    // Directed table: outputs checked in the cycle the row's inputs are applied.
    tbl[0]  = mk(1, 32'h1,  3'd0, 0, 3'd0, 0, 1, 2'd0, 0, 32'h0, 0);
    tbl[1]  = mk(1, 32'h2,  3'd1, 0, 3'd0, 0, 1, 2'd1, 0, 32'h0, 0);
    tbl[2]  = mk(1, 32'h4,  3'd2, 0, 3'd0, 0, 1, 2'd2, 0, 32'h0, 0);
    tbl[3]  = mk(1, 32'h8,  3'd3, 0, 3'd0, 0, 1, 2'd3, 0, 32'h0, 0);
    tbl[4]  = mk(1, 32'h10, 3'd4, 0, 3'd0, 0, 0, 2'd0, 0, 32'h0, 0);
    tbl[5]  = mk(1, 32'h20, 3'd4, 1, 3'd0, 0, 0, 2'd0, 0, 32'h0, 0);
    tbl[6]  = mk(0, 32'h0,  3'd0, 0, 3'd0, 0, 1, 2'd0, 0, 32'h0, 0);
    tbl[7]  = mk(0, 32'h0,  3'd0, 1, 3'd5, 0, 1, 2'd0, 0, 32'h0, 0);
    tbl[8]  = mk(1, 32'h40, 3'd6, 1, 3'd1, 1, 1, 2'd0, 0, 32'h0, OE_ON);
    tbl[9]  = mk(0, 32'h0,  3'd0, 0, 3'd0, 0, 0, 2'd0, 1, 32'h2, OE_ON);
    tbl[10] = mk(1, 32'h80, 3'd7, 1, 3'd0, 0, 0, 2'd0, 0, 32'h2, OE_ON);
    tbl[11] = mk(0, 32'h0,  3'd0, 0, 3'd0, 0, 0, 2'd0, 0, 32'h2, OE_ON);
    tbl[12] = mk(0, 32'h0,  3'd0, 0, 3'd0, 0, 1, 2'd0, 0, 32'h2, OE_ON);
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].take, tbl[i].vec, tbl[i].rob, tbl[i].cb, tbl[i].crob, tbl[i].cmisp);
      check($sformatf("tbl%0d_ready", i), snapReady, tbl[i].ready);
      check($sformatf("tbl%0d_tag", i), snapTag, tbl[i].tag);
      check($sformatf("tbl%0d_rv", i), restoreValid, tbl[i].rv);
      check($sformatf("tbl%0d_rest", i), statusRestore, tbl[i].rest);
      check($sformatf("tbl%0d_oe", i), orderErr, tbl[i].oe);
      tick();
    end
    idle_inputs();

    // Mispredict of the oldest checkpoint restores its vector and drains.
    apply_reset();
    drive(1, 32'h1, 3'd1, 0, 3'd0, 0); tick();
    drive(1, 32'h2, 3'd2, 0, 3'd0, 0); tick();
    drive(0, 32'h0, 3'd0, 1, 3'd1, 1); tick();
    idle_inputs();
    check("mis_rv", restoreValid, 1);
    check("mis_rest", statusRestore, 32'h1);
    check("mis_ready_restore", snapReady, 0);
    tick();
    for (int d = 0; d < DRAIN_CYC; d++) begin
      check($sformatf("mis_drain%0d_ready", d), snapReady, 0);
      check($sformatf("mis_drain%0d_rv", d), restoreValid, 0);
      tick();
    end
    check("mis_run_ready", snapReady, 1);
    check("mis_run_tag", snapTag, 0);
    check("mis_run_rest", statusRestore, 32'h1);

    // Wrap-around: allocate/pop pairs cycle through every slot tag.
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1, 32'h1 << i, 3'(i), 0, 3'd0, 0);
      check($sformatf("wrap%0d_tag", i), snapTag, i % SLOTS);
      check($sformatf("wrap%0d_ready", i), snapReady, 1);
      tick();
      drive(0, 32'h0, 3'd0, 1, 3'(i), 0);
      tick();
    end
    idle_inputs();
    check("wrap_oe", orderErr, 0);

    // Asynchronous reset in RESTORE and in DRAIN.
    for (int k = 0; k < 2; k++) begin
      apply_reset();
      drive(1, 32'hdead_beef, 3'd3, 0, 3'd0, 0); tick();
      drive(0, 32'h0, 3'd0, 1, 3'd3, 1); tick();
      idle_inputs();
      if (k == 1) tick();
      check($sformatf("arst%0d_pre_ready", k), snapReady, 0);
      check($sformatf("arst%0d_pre_rv", k), restoreValid, k == 0);
      #2;
      globalResetN = 1'b0;
      #1;
      check($sformatf("arst%0d_ready", k), snapReady, 1);
      check($sformatf("arst%0d_rv", k), restoreValid, 0);
      check($sformatf("arst%0d_rest", k), statusRestore, 0);
      check($sformatf("arst%0d_tag", k), snapTag, 0);
      check($sformatf("arst%0d_oe", k), orderErr, 0);
      tick();
      globalResetN = 1'b1;
    end

    // Randomized traffic against the reference model.
    apply_reset();
    model_reset();
    for (int c = 0; c < 500; c++) begin
      logic [2:0] crob;
      crob = 3'($urandom_range(0, 7));
      if (mq_rob.size() > 0 && $urandom_range(0, 3) != 0) crob = mq_rob[0];
      drive($urandom_range(0, 2) != 0, $urandom, 3'($urandom_range(0, 7)),
            $urandom_range(0, 2) == 0, crob, $urandom_range(0, 7) == 0);
      model_check($sformatf("rnd%0d", c));
      model_step();
      tick();
    end
    idle_inputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
